// File: rtl/cpu_pkg.sv
// Shared definitions for the core sequencer: state encoding and the default
// load/store and div/rem code ranges also used by the decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXECUTE  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_MC_WAIT  = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    localparam int unsigned LS_FIRST_DEF = 27;
    localparam int unsigned LS_LAST_DEF  = 34;
    localparam int unsigned MC_FIRST_DEF = 14;
    localparam int unsigned MC_LAST_DEF  = 17;

    // Inclusive range test on a decoded instruction code.
    function automatic logic code_in_range(input logic [63:0] code,
                                           input logic [63:0] lo,
                                           input logic [63:0] hi);
        return (code >= lo) && (code <= hi);
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on the bus; expired flags the terminal count
// BUS_TIMEOUT-1. With BUS_TIMEOUT=0 the counter disappears and never expires.
module bus_timeout_counter #(
    parameter int unsigned BUS_TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (BUS_TIMEOUT == 0) begin : g_off
            logic unused;
            assign unused  = &{1'b0, clk, rst_n, clear, enable};
            assign expired = 1'b0;
        end else begin : g_on
            localparam int unsigned W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
            localparam logic [W-1:0] LAST = W'(BUS_TIMEOUT - 1);

            logic [W-1:0] count;

            // Saturates at LAST so a stalled enable cannot wrap back to zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    count <= '0;
                else if (clear)
                    count <= '0;
                else if (enable && (count != LAST))
                    count <= count + 1'b1;
            end

            assign expired = (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, optional decode, execute, and wait
// states for load/store and div/rem, with halt handshake and bus timeout fault.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned CODE_W       = 32,
    parameter int unsigned LS_FIRST     = LS_FIRST_DEF,
    parameter int unsigned LS_LAST      = LS_LAST_DEF,
    parameter int unsigned MC_FIRST     = MC_FIRST_DEF,
    parameter int unsigned MC_LAST      = MC_LAST_DEF,
    parameter int unsigned DECODE_STAGE = 0,
    parameter int unsigned BUS_TIMEOUT  = 256,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bus_DV,
    input  logic [CODE_W-1:0] i_instruction,
    input  logic              i_div_rem_finnished,
    input  logic              i_halt,
    input  logic              i_fault_clr,
    output logic [2:0]        o_state,
    output logic              o_load_PC,
    output logic              o_start_fetch,
    output logic              o_start_mem,
    output logic              o_start_mc,
    output logic              o_fault,
    output logic [CNT_W-1:0]  o_instret
);

    state_t     state;
    state_t     state_next;
    logic       start_fetch_next;
    logic       complete;
    logic       is_ls;
    logic       is_mc;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;

    // Load/store wins where the two ranges overlap.
    assign is_ls = code_in_range(64'(i_instruction), 64'(LS_FIRST), 64'(LS_LAST));
    assign is_mc = !is_ls &&
                   code_in_range(64'(i_instruction), 64'(MC_FIRST), 64'(MC_LAST));

    always_comb begin
        state_next       = state;
        start_fetch_next = 1'b0;
        complete         = 1'b0;
        o_start_mem      = 1'b0;
        o_start_mc       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!i_halt) begin
                    state_next       = ST_FETCH;
                    start_fetch_next = 1'b1;
                end
            end
            ST_FETCH: begin
                if (i_bus_DV)
                    state_next = (DECODE_STAGE != 0) ? ST_DECODE : ST_EXECUTE;
                else if (tmo_expired)
                    state_next = ST_FAULT;
            end
            ST_DECODE: begin
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_ls) begin
                    o_start_mem = 1'b1;
                    state_next  = ST_MEM_WAIT;
                end else if (is_mc) begin
                    o_start_mc = 1'b1;
                    state_next = ST_MC_WAIT;
                end else begin
                    complete = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (i_bus_DV)
                    complete = 1'b1;
                else if (tmo_expired)
                    state_next = ST_FAULT;
            end
            ST_MC_WAIT: begin
                if (i_div_rem_finnished)
                    complete = 1'b1;
            end
            ST_FAULT: begin
                if (i_fault_clr)
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Halt is honoured only here and in IDLE, never mid-instruction.
        if (complete) begin
            if (i_halt) begin
                state_next = ST_IDLE;
            end else begin
                state_next       = ST_FETCH;
                start_fetch_next = 1'b1;
            end
        end
    end

    // The timeout window restarts on every entry into a bus wait state,
    // including the direct MEM_WAIT -> FETCH hop on completion.
    assign tmo_clear  = (state_next != state) &&
                        ((state_next == ST_FETCH) || (state_next == ST_MEM_WAIT));
    assign tmo_enable = ((state == ST_FETCH) || (state == ST_MEM_WAIT)) &&
                        (state_next == state);

    bus_timeout_counter #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_tmo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            o_start_fetch <= 1'b0;
            o_instret     <= '0;
        end else begin
            state         <= state_next;
            o_start_fetch <= start_fetch_next;
            if (complete)
                o_instret <= o_instret + 1'b1;
        end
    end

    assign o_state   = state;
    assign o_load_PC = complete;
    assign o_fault   = (state == ST_FAULT);

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Parametrised multi-cycle instruction sequencer for the RISC-V core.
- Sits between the fetch/bus interface, the decoder, the load/store path and the multi-cycle div/rem unit.
- Generalises the two-state fetch/execute controller with explicit wait states, an optional decode stage, a halt handshake, bus timeout with sticky fault, and a retired-instruction counter.

Parameters:
- CODE_W, 32: width of decoded instruction code i_instruction
- LS_FIRST, 27: first load/store code (inclusive)
- LS_LAST, 34: last load/store code (inclusive)
- MC_FIRST, 14: first multi-cycle (div/rem) code (inclusive)
- MC_LAST, 17: last multi-cycle code (inclusive)
- DECODE_STAGE, 0: 1 inserts a one-cycle DECODE state between FETCH and EXECUTE
- BUS_TIMEOUT, 256: max cycles waiting for i_bus_DV in FETCH/MEM_WAIT; 0 disables timeout
- CNT_W, 32: width of o_instret

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_bus_DV  in  1  bus data-valid (fetch word or memory access complete)
- i_instruction  in  CODE_W  decoded instruction code, stable from EXECUTE until completion
- i_div_rem_finnished  in  1  multi-cycle unit done
- i_halt  in  1  request to stop before next fetch
- i_fault_clr  in  1  clears FAULT
- o_state  out  3  current state encoding
- o_load_PC  out  1  PC update strobe, one cycle per retired instruction
- o_start_fetch  out  1  one-cycle fetch request pulse
- o_start_mem  out  1  one-cycle load/store start pulse
- o_start_mc  out  1  one-cycle div/rem start pulse
- o_fault  out  1  bus timeout fault, sticky
- o_instret  out  CNT_W  retired instruction count

Behaviour:
- One clock: i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state IDLE, all pulses 0, o_fault 0, o_instret 0, timeout counter 0.
- Reset mid-operation aborts immediately to IDLE. No pulse is emitted during reset.
- State encoding (o_state): IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM_WAIT=4, MC_WAIT=5, FAULT=6.
- IDLE:
  - if i_halt=0: register o_start_fetch=1 and go to FETCH.
  - else stay in IDLE.
- FETCH:
  - on i_bus_DV: go to DECODE if DECODE_STAGE=1, else EXECUTE.
- DECODE: unconditional move to EXECUTE after 1 cycle.
- EXECUTE (always exactly 1 cycle), classified on i_instruction:
  - LS_FIRST..LS_LAST: o_start_mem=1 (combinational, this cycle), next state MEM_WAIT.
  - MC_FIRST..MC_LAST: o_start_mc=1 (combinational), next state MC_WAIT.
  - otherwise: the instruction completes this cycle.
- MEM_WAIT: completes on i_bus_DV.
- MC_WAIT: completes on i_div_rem_finnished.
- Completion cycle:
  - o_load_PC=1 (combinational, same cycle).
  - o_instret increments at the clock edge, wrapping modulo 2^CNT_W.
  - next state FETCH with registered o_start_fetch=1 in the following cycle if i_halt=0; IDLE if i_halt=1.
- Latency with DECODE_STAGE=0:
  - ALU op: 2 cycles from fetch DV to next start_fetch.
  - mem op: load_PC in the DV cycle, start_fetch 1 cycle later.
- Timeout:
  - Counter clears on entry to FETCH/MEM_WAIT and increments each waiting cycle.
  - If the counter reaches BUS_TIMEOUT-1 with no DV: next state FAULT, o_fault=1, no load_PC.
  - DV in the terminal-count cycle wins (normal progress).
- FAULT:
  - all pulses 0; o_fault held at 1.
  - i_fault_clr=1 -> IDLE, o_fault=0.
- Ignored inputs:
  - i_bus_DV in IDLE, DECODE, EXECUTE, MC_WAIT, FAULT.
  - i_div_rem_finnished outside MC_WAIT.
  - i_fault_clr outside FAULT.
- Overlapping code ranges: load/store has priority over multi-cycle.
- i_halt is sampled only in IDLE and in completion cycles; a halt asserted mid-instruction does not abort it.

Decomposition:
- Shared package cpu_pkg:
  - state encoding constants (IDLE..FAULT).
  - default LS/MC code range constants, shared with the decoder.
- One natural sub-module: bus_timeout_counter.
  - inputs: clear, enable.
  - parameter: BUS_TIMEOUT.
  - output: expired (constant 0 when BUS_TIMEOUT=0).

Test Plan:
- Reset, i_halt=0, fetch DV on cycle 3, code 5 (ALU):
  - start_fetch pulses at cycle 1.
  - EXECUTE at cycle 4 with load_PC=1.
  - start_fetch at cycle 5; instret=1.
- Code 30 (load), bus DV 4 cycles after start_mem:
  - start_mem exactly 1 cycle.
  - state 4 for 4 cycles.
  - load_PC in the DV cycle; instret=1.
- Code 15 (div), finished 33 cycles after start_mc:
  - stays in MC_WAIT; load_PC only on the finished cycle.
  - bus DV pulses during MC_WAIT are ignored.
- BUS_TIMEOUT=8, no fetch DV:
  - FAULT after 8 cycles in FETCH; o_fault=1; instret unchanged.
  - i_fault_clr -> IDLE -> new start_fetch.
  - Repeat with DV on the 8th cycle -> no fault.
- DECODE_STAGE=1, i_halt raised during MEM_WAIT:
  - DECODE adds exactly 1 cycle.
  - completion goes to IDLE with no start_fetch.
  - dropping halt gives start_fetch next cycle.
  - async reset mid-MEM_WAIT returns to state 0 immediately.
